axil_multi_adder: RTL and testbench
===================================

# axil_multi_adder

Parametrised AXI4-Lite slave that provides NUM_CH independent adder channels, each with its own operands, mode, result and carry, plus a shared status register. It replaces the single-channel memory-mapped adder. It sits on the s1 AXI-Lite port of the lab interconnect and is software-programmed: write operands, write start, poll done, read result.

## Interface
- DATA_WIDTH, 32, AXI data width and the width of operands and results; must be a multiple of 8.
- ADDR_WIDTH, 8, AXI address width; must be ≥ 8.
- NUM_CH, 4, number of channels; range 1..8.
- s1_axi_aclk  in  1  single clock.
- s1_axi_aresetn  in  1  reset, synchronous and active-low.
- s1_axi_awaddr / s1_axi_awvalid / s1_axi_awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- s1_axi_wdata / s1_axi_wstrb / s1_axi_wvalid / s1_axi_wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- s1_axi_bresp / s1_axi_bvalid / s1_axi_bready  out/out/in  2/1/1  write response; 00 OKAY, 10 SLVERR.
- s1_axi_araddr / s1_axi_arvalid / s1_axi_arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- s1_axi_rdata / s1_axi_rresp / s1_axi_rvalid / s1_axi_rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.

## Operation
- Address decode uses addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored. Channel c occupies base 16·c.
  - +0x0 A: RW, byte-strobed.
  - +0x4 B: RW, byte-strobed.
  - +0x8 CTRL: RW. Bit 0 START, write-only, reads 0. Bits [2:1] MODE.
  - +0xC RESULT: RO.
- STATUS at 0x80, RO. Bits [NUM_CH-1:0] DONE. Bits [8+NUM_CH-1:8] CARRY. All other bits read 0.
- MODE encoding:
  - 00: RESULT = A+B.
  - 01: RESULT = A−B; CARRY = borrow.
  - 10: RESULT = RESULT+A (accumulate).
  - 11: reserved.
- Arithmetic is unsigned and modulo 2^DATA_WIDTH. The carry/borrow out of the MSB is stored in CARRY[c].
- A CTRL write uses wstrb[0] only. If wstrb[0]=0, CTRL is unchanged, nothing starts, and the response is OKAY.
- A CTRL write with MODE=11 returns SLVERR, leaves CTRL unchanged and does not start.
- SLVERR is returned for:
  - writes to RESULT, STATUS, or any unmapped address (channel ≥ NUM_CH, or above 0x80); state is unchanged;
  - reads of unmapped addresses; rdata is 0.
- Reading STATUS clears every DONE bit that was set at read acceptance. CARRY bits are not cleared by the read.
- A START clears DONE[c] in the acceptance cycle and recomputes from the current registers.

## Timing
- Reset values:
  - all ready/valid outputs 0; bresp, rresp, rdata 0;
  - all A, B, CTRL, RESULT, DONE, CARRY registers 0.
- Write handshake:
  - awready = wready = awvalid & wvalid & ~bvalid. Both fire in the same cycle; there is no partial acceptance.
  - bvalid rises on the edge after acceptance and holds until bready.
  - No new write is accepted while bvalid=1.
- Read handshake:
  - arready = ~rvalid.
  - rvalid and rdata are registered on the acceptance edge and hold stable until rready.
- Reads and writes are accepted in the same cycle independently. A read sees register contents from before a same-cycle write.
- Compute latency:
  - START is accepted at edge E.
  - RESULT, CARRY[c] and DONE[c] update at edge E+1.
  - A read accepted at or after E+1 returns the new values.
  - A read of RESULT accepted at E returns the old value.
- Simultaneous events:
  - A DONE set and a STATUS read-clear in the same cycle: the set wins.
  - A START arriving while the previous compute is in flight is not possible, because each compute takes one cycle.
- Reset asserted mid-transaction or mid-compute: everything returns to reset values on that edge, and the in-flight response is dropped.

## Structure
- Package axil_adder_pkg holds:
  - register offsets (A_OFF, B_OFF, CTRL_OFF, RES_OFF, STATUS_ADDR);
  - MODE encodings;
  - RESP_OKAY / RESP_SLVERR.
- Sub-module adder_channel, instantiated NUM_CH times via generate:
  - holds A, B, CTRL, RESULT, CARRY and DONE;
  - inputs: write enable, offset, wdata, wstrb, clear_done;
  - outputs: register read-back.
- The top level contains the AXI handshake logic, address decode and read mux.

## Test plan
- Write 39→0x00 and 40→0x04, then 0x1 to 0x08 (add) -> read 0x0C = 79; STATUS = 0x001 on the first read, 0x000 on the second read.
- Channel 1: A=5, B=7, write 0x3 to 0x18 (sub) -> 0x1C = 0xFFFFFFFE; STATUS bit 9 = 1; bit 1 set.
- Channel 2: A=0xFFFFFFFF, then write 0x5 (accumulate) to 0x28 twice -> RESULT goes 0xFFFFFFFF then 0xFFFFFFFE; CARRY[2] = 1 after the second start.
- Write to 0xC0, 0x0C and 0x80, and write CTRL=0x7 -> each bresp = 10 with no state change; read 0xC0 -> rresp = 10, rdata = 0.
- Hold bready=0 for 5 cycles after a write -> bvalid held, awready/wready stay 0 for the next write; same check for a read with rready=0 (rdata stable).
- Assert aresetn=0 in the cycle after START is accepted -> at the next edge all outputs and registers are 0 and STATUS reads 0 after release.

Source files
------------

// File: rtl/axil_adder_pkg.sv
// Shared constants for the multi-channel AXI4-Lite adder.
// Register offsets are word offsets inside a 16-byte channel window
// (address bits [3:2]). STATUS sits at a fixed byte address.
package axil_adder_pkg;

    localparam logic [1:0] A_OFF    = 2'd0;  // byte +0x0
    localparam logic [1:0] B_OFF    = 2'd1;  // byte +0x4
    localparam logic [1:0] CTRL_OFF = 2'd2;  // byte +0x8
    localparam logic [1:0] RES_OFF  = 2'd3;  // byte +0xC

    localparam logic [7:0] STATUS_ADDR = 8'h80;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/adder_channel.sv
// One adder channel: operand registers A/B, mode, result, carry and done.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   wr_en           legal write to this channel (already filtered by the top)
//   wr_off          word offset of the write (A, B or CTRL)
//   wdata, wstrb    write data and byte strobes
//   clear_done      STATUS read accepted this cycle
//   a, b, mode,
//   result, carry,
//   done            register read-back
module adder_channel
    import axil_adder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [1:0]              wr_off,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    clear_done,
    output logic [DATA_WIDTH-1:0]   a,
    output logic [DATA_WIDTH-1:0]   b,
    output logic [1:0]              mode,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    carry,
    output logic                    done
);

    logic [DATA_WIDTH-1:0] a_q, b_q, result_q;
    logic [1:0]            mode_q;
    logic                  carry_q, done_q, start_q;
    logic [DATA_WIDTH:0]   sum;
    logic                  start_wr;

    // Top bit of sum is the carry (add/acc) or borrow (sub) out of the MSB.
    always_comb begin
        sum = '0;
        case (mode_q)
            MODE_ADD: sum = {1'b0, a_q} + {1'b0, b_q};
            MODE_SUB: sum = {1'b0, a_q} - {1'b0, b_q};
            MODE_ACC: sum = {1'b0, result_q} + {1'b0, a_q};
            default:  sum = '0;
        endcase
    end

    assign start_wr = wr_en && (wr_off == CTRL_OFF) && wdata[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            mode_q   <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            start_q <= start_wr;
            if (wr_en) begin
                case (wr_off)
                    A_OFF: begin
                        for (int i = 0; i < DATA_WIDTH / 8; i++)
                            if (wstrb[i]) a_q[8*i +: 8] <= wdata[8*i +: 8];
                    end
                    B_OFF: begin
                        for (int i = 0; i < DATA_WIDTH / 8; i++)
                            if (wstrb[i]) b_q[8*i +: 8] <= wdata[8*i +: 8];
                    end
                    CTRL_OFF: mode_q <= wdata[2:1];
                    default: ;
                endcase
            end
            // Compute lands one edge after START acceptance.
            if (start_q) begin
                result_q <= sum[DATA_WIDTH-1:0];
                carry_q  <= sum[DATA_WIDTH];
            end
            // A completing compute beats a same-cycle STATUS read-clear.
            if (start_q) done_q <= 1'b1;
            else if (start_wr || clear_done) done_q <= 1'b0;
        end
    end

    assign a      = a_q;
    assign b      = b_q;
    assign mode   = mode_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign done   = done_q;

endmodule

// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave exposing NUM_CH adder channels (16 bytes each from 0x00)
// and a STATUS register at 0x80 (DONE in [NUM_CH-1:0], CARRY in [8+NUM_CH-1:8]).
// Ports: s1_axi_aclk/s1_axi_aresetn clock and synchronous active-low reset;
// standard AXI4-Lite AW, W, B, AR and R channels on the s1_axi_ prefix.
module axil_multi_adder
    import axil_adder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic                    s1_axi_aclk,
    input  logic                    s1_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready
);

    localparam int unsigned           CW        = ADDR_WIDTH - 4;
    localparam logic [CW-1:0]         NUM_CH_W  = CW'(NUM_CH);
    localparam logic [ADDR_WIDTH-1:0] STATUS_A  = ADDR_WIDTH'(STATUS_ADDR);

    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  wr_fire, rd_fire, clear_done;
    logic [CW-1:0]         w_ch, r_ch;
    logic [1:0]            w_off, r_off;
    logic                  w_ch_hit, r_ch_hit, r_status;
    logic                  w_en_ok;
    logic [1:0]            w_resp, r_resp;
    logic [DATA_WIDTH-1:0] r_data, status;

    logic [NUM_CH-1:0]     ch_wr_en, ch_carry, ch_done;
    logic [DATA_WIDTH-1:0] ch_a      [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_b      [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_result [NUM_CH];
    logic [1:0]            ch_mode   [NUM_CH];

    logic unused_addr;
    assign unused_addr = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0]};

    // Readies are held low while reset is asserted so nothing is accepted then.
    assign wr_fire = s1_axi_aresetn && s1_axi_awvalid && s1_axi_wvalid && !bvalid_q;
    assign rd_fire = s1_axi_aresetn && s1_axi_arvalid && !rvalid_q;
    assign s1_axi_awready = wr_fire;
    assign s1_axi_wready  = wr_fire;
    assign s1_axi_arready = s1_axi_aresetn && !rvalid_q;

    // Write decode
    assign w_ch     = s1_axi_awaddr[ADDR_WIDTH-1:4];
    assign w_off    = s1_axi_awaddr[3:2];
    assign w_ch_hit = (w_ch < NUM_CH_W);

    always_comb begin
        w_resp  = RESP_SLVERR;
        w_en_ok = 1'b0;
        if (w_ch_hit) begin
            case (w_off)
                A_OFF, B_OFF: begin
                    w_resp  = RESP_OKAY;
                    w_en_ok = 1'b1;
                end
                CTRL_OFF: begin
                    // Without wstrb[0] the CTRL write is a silent no-op.
                    if (!s1_axi_wstrb[0]) begin
                        w_resp = RESP_OKAY;
                    end else if (s1_axi_wdata[2:1] != MODE_RSVD) begin
                        w_resp  = RESP_OKAY;
                        w_en_ok = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read decode
    assign r_ch       = s1_axi_araddr[ADDR_WIDTH-1:4];
    assign r_off      = s1_axi_araddr[3:2];
    assign r_ch_hit   = (r_ch < NUM_CH_W);
    assign r_status   = ({s1_axi_araddr[ADDR_WIDTH-1:2], 2'b00} == STATUS_A);
    assign clear_done = rd_fire && r_status;

    always_comb begin
        status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            status[c]     = ch_done[c];
            status[8 + c] = ch_carry[c];
        end
    end

    always_comb begin
        r_data = '0;
        r_resp = RESP_SLVERR;
        if (r_status) begin
            r_data = status;
            r_resp = RESP_OKAY;
        end else if (r_ch_hit) begin
            r_resp = RESP_OKAY;
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_ch == CW'(c)) begin
                    case (r_off)
                        A_OFF:    r_data = ch_a[c];
                        B_OFF:    r_data = ch_b[c];
                        CTRL_OFF: r_data = {{(DATA_WIDTH-3){1'b0}}, ch_mode[c], 1'b0};
                        default:  r_data = ch_result[c];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge s1_axi_aclk) begin
        if (!s1_axi_aresetn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= w_resp;
            end else if (s1_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= r_data;
                rresp_q  <= r_resp;
            end else if (s1_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s1_axi_bvalid = bvalid_q;
    assign s1_axi_bresp  = bresp_q;
    assign s1_axi_rvalid = rvalid_q;
    assign s1_axi_rresp  = rresp_q;
    assign s1_axi_rdata  = rdata_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_wr_en[g] = wr_fire && w_en_ok && (w_ch == CW'(g));

        adder_channel #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ch (
            .clk        (s1_axi_aclk),
            .rst_n      (s1_axi_aresetn),
            .wr_en      (ch_wr_en[g]),
            .wr_off     (w_off),
            .wdata      (s1_axi_wdata),
            .wstrb      (s1_axi_wstrb),
            .clear_done (clear_done),
            .a          (ch_a[g]),
            .b          (ch_b[g]),
            .mode       (ch_mode[g]),
            .result     (ch_result[g]),
            .carry      (ch_carry[g]),
            .done       (ch_done[g])
        );
    end

endmodule

// File: tb/tb_axil_multi_adder.sv
// Self-checking bench for axil_multi_adder (default parameters).
// Expected responses are queued when a transaction is issued and compared
// when the DUT returns the matching B or R beat.
module tb_axil_multi_adder;
    import axil_adder_pkg::*;

    localparam int TIMEOUT = 50;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic [1:0] b_exp_q [$];
    rexp_t      r_exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axil_multi_adder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .NUM_CH     (4)
    ) dut (
        .s1_axi_aclk    (clk),
        .s1_axi_aresetn (aresetn),
        .s1_axi_awaddr  (awaddr),
        .s1_axi_awvalid (awvalid),
        .s1_axi_awready (awready),
        .s1_axi_wdata   (wdata),
        .s1_axi_wstrb   (wstrb),
        .s1_axi_wvalid  (wvalid),
        .s1_axi_wready  (wready),
        .s1_axi_bresp   (bresp),
        .s1_axi_bvalid  (bvalid),
        .s1_axi_bready  (bready),
        .s1_axi_araddr  (araddr),
        .s1_axi_arvalid (arvalid),
        .s1_axi_arready (arready),
        .s1_axi_rdata   (rdata),
        .s1_axi_rresp   (rresp),
        .s1_axi_rvalid  (rvalid),
        .s1_axi_rready  (rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: {carry, result}
    function automatic logic [32:0] model(input logic [1:0] m, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] r);
        case (m)
            MODE_ADD: return {1'b0, a} + {1'b0, b};
            MODE_SUB: return {1'b0, a} - {1'b0, b};
            default:  return {1'b0, r} + {1'b0, a};
        endcase
    endfunction

    task automatic wait_b(input string tag);
        logic [1:0] exp;
        int n = 0;
        while (!bvalid && n < TIMEOUT) begin
            @(posedge clk); #1; n++;
        end
        exp = b_exp_q.pop_front();
        check({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        if (bvalid) begin
            check({tag, "_bresp"}, {30'd0, bresp}, {30'd0, exp});
            @(posedge clk); #1;
        end
    endtask

    task automatic axi_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        int n = 0;
        b_exp_q.push_back(exp_resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!(awready && wready) && n < TIMEOUT) begin
            @(posedge clk); #1; n++;
        end
        if (!(awready && wready)) begin
            check({tag, "_awready"}, {31'd0, awready}, 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            void'(b_exp_q.pop_front());
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_b(tag);
    endtask

    task automatic axi_read(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        rexp_t e;
        int n = 0;
        r_exp_q.push_back('{resp: exp_resp, data: exp_data});
        araddr = addr; arvalid = 1'b1;
        #1;
        while (!arready && n < TIMEOUT) begin
            @(posedge clk); #1; n++;
        end
        if (!arready) begin
            check({tag, "_arready"}, {31'd0, arready}, 32'd1);
            arvalid = 1'b0;
            void'(r_exp_q.pop_front());
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        e = r_exp_q.pop_front();
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check({tag, "_rresp"}, {30'd0, rresp}, {30'd0, e.resp});
        check({tag, "_rdata"}, rdata, e.data);
        @(posedge clk); #1;
    endtask

    initial begin : main
        logic [32:0] m;
        rexp_t       e;
        int          n;

        aresetn = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        axi_read("rst_status", 8'h80, 32'h0, RESP_OKAY);
        axi_read("rst_res0", 8'h0C, 32'h0, RESP_OKAY);

        // Channel 0 add
        axi_write("c0_a", 8'h00, 32'd39, 4'hF, RESP_OKAY);
        axi_write("c0_b", 8'h04, 32'd40, 4'hF, RESP_OKAY);
        axi_write("c0_go", 8'h08, 32'h1, 4'hF, RESP_OKAY);
        m = model(MODE_ADD, 32'd39, 32'd40, 32'd0);
        axi_read("c0_res", 8'h0C, m[31:0], RESP_OKAY);
        axi_read("c0_st1", 8'h80, 32'h001, RESP_OKAY);
        axi_read("c0_st2", 8'h80, 32'h000, RESP_OKAY);
        axi_read("c0_ctrl", 8'h08, 32'h0, RESP_OKAY);

        // Channel 1 subtract with borrow
        axi_write("c1_a", 8'h10, 32'd5, 4'hF, RESP_OKAY);
        axi_write("c1_b", 8'h14, 32'd7, 4'hF, RESP_OKAY);
        axi_write("c1_go", 8'h18, 32'h3, 4'hF, RESP_OKAY);
        axi_read("c1_res", 8'h1C, 32'hFFFF_FFFE, RESP_OKAY);
        axi_read("c1_st", 8'h80, 32'h202, RESP_OKAY);
        axi_read("c1_ctrl", 8'h18, 32'h2, RESP_OKAY);

        // Channel 2 accumulate twice
        axi_write("c2_a", 8'h20, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
        axi_write("c2_go1", 8'h28, 32'h5, 4'hF, RESP_OKAY);
        axi_read("c2_res1", 8'h2C, 32'hFFFF_FFFF, RESP_OKAY);
        axi_write("c2_go2", 8'h28, 32'h5, 4'hF, RESP_OKAY);
        axi_read("c2_res2", 8'h2C, 32'hFFFF_FFFE, RESP_OKAY);
        axi_read("c2_st", 8'h80, 32'h604, RESP_OKAY);

        // Byte strobes on channel 3 A
        axi_write("c3_a", 8'h30, 32'h1122_3344, 4'b0101, RESP_OKAY);
        axi_read("c3_a", 8'h30, 32'h0022_0044, RESP_OKAY);

        // Error responses leave state unchanged
        axi_write("err_c0", 8'hC0, 32'h1, 4'hF, RESP_SLVERR);
        axi_write("err_ch4", 8'h40, 32'h1, 4'hF, RESP_SLVERR);
        axi_write("err_res", 8'h0C, 32'h1234, 4'hF, RESP_SLVERR);
        axi_write("err_st", 8'h80, 32'hFFFF, 4'hF, RESP_SLVERR);
        axi_write("err_m3", 8'h18, 32'h7, 4'hF, RESP_SLVERR);
        axi_write("nostrb", 8'h08, 32'h3, 4'hE, RESP_OKAY);
        axi_read("err_res0", 8'h0C, 32'd79, RESP_OKAY);
        axi_read("err_ctl1", 8'h18, 32'h2, RESP_OKAY);
        axi_read("err_ctl0", 8'h08, 32'h0, RESP_OKAY);
        axi_read("err_st", 8'h80, 32'h600, RESP_OKAY);
        axi_read("err_rd", 8'hC0, 32'h0, RESP_SLVERR);

        // START and RESULT read accepted on the same edge: read sees old value
        b_exp_q.push_back(RESP_OKAY);
        r_exp_q.push_back('{resp: RESP_OKAY, data: 32'h0});
        awaddr = 8'h38; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h3C; arvalid = 1'b1;
        #1;
        check("same_awready", {31'd0, awready}, 32'd1);
        check("same_arready", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        e = r_exp_q.pop_front();
        check("same_rdata", rdata, e.data);
        check("same_bresp", {30'd0, bresp}, {30'd0, b_exp_q.pop_front()});
        @(posedge clk); #1;
        m = model(MODE_ADD, 32'h0022_0044, 32'h0, 32'h0);
        axi_read("c3_res", 8'h3C, m[31:0], RESP_OKAY);

        // Write response backpressure
        bready = 1'b0;
        b_exp_q.push_back(RESP_OKAY);
        awaddr = 8'h34; wdata = 32'd3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < TIMEOUT) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        awaddr = 8'h24; wdata = 32'd9;  // next write waits behind bvalid
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", {31'd0, bvalid}, 32'd1);
            check("bp_awready", {30'd0, awready, wready}, 32'd0);
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_bresp", {30'd0, bresp}, {30'd0, b_exp_q.pop_front()});
        bready = 1'b1;
        @(posedge clk); #1;
        check("bp_bdrop", {31'd0, bvalid}, 32'd0);
        axi_read("bp_c2b", 8'h24, 32'd0, RESP_OKAY);

        // Read data backpressure
        rready = 1'b0;
        r_exp_q.push_back('{resp: RESP_OKAY, data: 32'd3});
        araddr = 8'h34; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < TIMEOUT) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        e = r_exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("rp_rvalid", {31'd0, rvalid}, 32'd1);
            check("rp_rdata", rdata, e.data);
            check("rp_arready", {31'd0, arready}, 32'd0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;

        // Reset the cycle after START acceptance
        awaddr = 8'h08; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < TIMEOUT) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge clk); #1;
        check("mr_bvalid", {31'd0, bvalid}, 32'd0);
        check("mr_rdata", rdata, 32'd0);
        check("mr_arready", {31'd0, arready}, 32'd0);
        aresetn = 1'b1;
        @(posedge clk); #1;
        axi_read("mr_status", 8'h80, 32'h0, RESP_OKAY);
        axi_read("mr_a0", 8'h00, 32'h0, RESP_OKAY);
        axi_read("mr_res0", 8'h0C, 32'h0, RESP_OKAY);
        axi_read("mr_res1", 8'h1C, 32'h0, RESP_OKAY);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
